eeprom_bist: RTL and testbench
==============================

// Module: eeprom_bist
// PURPOSE
// - Self-test sequencer for an I2C EEPROM; drives the byte-level IIC master (exec/done/ack handshake) on iic_4_clk.
// - Per run: writes a pattern over a programmable address window, then reads back and compares.
// - Restartable runs, selectable mode and pattern, NACK retry on writes, error count and first-fail address.
// PARAMETERS
// - ADDR16      1      1: 16-bit word address (iic_bit_ctrl=1); 0: 8-bit address, iic_addr[15:8] forced 0
// - START_ADDR  16'h0  first address of the test window
// - LENGTH      256    bytes per run; must be >=1 (elaboration check)
// - WR_WAIT     5000   iic_4_clk cycles of idle after every write transaction (tWR), including retries
// - MAX_RETRY   3      extra attempts of a write that ends with NACK
// PORTS
// - iic_4_clk     in   1   clock
// - rstn          in   1   async active-low reset
// - start         in   1   one-cycle run request; ignored while busy
// - mode          in   2   sampled at start: 0 write+verify, 1 write only, 2 verify only, 3 = treated as 0
// - pattern       in   2   sampled at start: 0 addr[7:0], 1 ~addr[7:0], 2 LFSR8, 3 addr[0]?8'hAA:8'h55
// - iic_done      in   1   one-cycle pulse, transaction finished
// - iic_ack       in   1   1 = NACK/error in the finished transaction
// - iic_data_r    in   8   read data, valid with iic_done
// - iic_bit_ctrl  out  1   constant = ADDR16
// - iic_exec      out  1   one-cycle transaction request
// - iic_rh_wl     out  1   1 read, 0 write; stable from exec to done
// - iic_addr      out  16  word address
// - iic_data_w    out  8   write data
// - busy          out  1   high from the cycle after start until result_done
// - result_done   out  1   one-cycle pulse at end of run
// - result_flag   out  1   1 pass; held until next start
// - err_cnt       out  16  read mismatches + read NACKs (saturating); held until next start
// - fail_addr     out  16  address of first failure; 16'hFFFF if none
// BEHAVIOUR
// - Reset: all outputs 0 except fail_addr=16'hFFFF; state IDLE. Reset mid-run aborts immediately; iic_exec drops
//   asynchronously; no result_done is generated.
// - States: IDLE, WR_REQ, WR_WAIT, WR_GAP, RD_REQ, RD_WAIT, DONE.
// - IDLE: on start, latch mode/pattern, addr_cnt=0, LFSR=8'hA5, clear err_cnt/flag, fail_addr=FFFF, busy=1.
//   Next state is WR_REQ, or RD_REQ when mode=2.
// - WR_REQ: exec=1 for one cycle, rh_wl=0, addr=START_ADDR+addr_cnt (mod 2^16, upper byte 0 if !ADDR16).
//   data=pattern(addr). Next state WR_WAIT.
// - WR_WAIT: on done:
//   - ack=0: load gap counter WR_WAIT-1, then WR_GAP.
//   - ack=1 and retry<MAX_RETRY: retry++, WR_GAP, then repeat the same address.
//   - ack=1 and retries exhausted: fail_addr=addr if first failure, result_flag=0, go to DONE (abort).
// - WR_GAP: count down to 0. Then advance addr_cnt and retry=0 (unless retrying), or, after the last address:
//   - mode 1: DONE, pass.
//   - otherwise: addr_cnt=0, LFSR reseeded to 8'hA5, then RD_REQ.
// - RD_REQ: exec pulse, rh_wl=1, same addressing. Next state RD_WAIT.
// - RD_WAIT: on done, error if ack=1 or data_r != pattern(addr). An error increments err_cnt (saturating at FFFF) and
//   captures fail_addr on the first failure only. The read run does NOT stop on error. After the last address,
//   go to DONE.
// - DONE: result_done=1 for one cycle; result_flag=1 only if no write abort and err_cnt=0. Busy clears the same cycle.
//   Next state IDLE.
// - LFSR8: x^8+x^6+x^5+x^4+1, Galois form, steps once per accepted address, so write and verify sequences match.
// - Exactly one iic transaction is outstanding at a time. iic_done is ignored in every state except WR_WAIT/RD_WAIT.
// - Address wrap: window crossing FFFF (or FF if !ADDR16) wraps to 0; no error is raised.
// STRUCTURE
// - eeprom_pkg: state encoding, MODE_* and PAT_* constants, LFSR seed/taps.
// - Sub-module eeprom_pattern_gen: pattern select plus LFSR register, with seed and step inputs and an 8-bit data
//   output.
// TESTING (bench EEPROM model behind a behavioural IIC master)
// - LENGTH=4, START=0, mode0, pattern0 -> writes 00..03; 4 reads; result_done pulse, flag=1, err_cnt=0,
//   fail_addr=FFFF.
// - Model corrupts byte at addr 2 -> flag=0, err_cnt=1, fail_addr=0002; reads of addr 3 still issued.
// - Model NACKs first 2 writes of addr 1, MAX_RETRY=3 -> 3 writes to addr 1, each followed by WR_WAIT idle
//   cycles; flag=1.
// - Model NACKs every write of addr 0 -> 4 attempts, DONE without any read, flag=0, fail_addr=0000.
// - ADDR16=0, START=8'hFE, LENGTH=4, pattern2 -> addresses FE,FF,00,01; data = A5 then LFSR steps; mode2 rerun on
//   same image passes.
// - Assert rstn mid-WR_GAP -> outputs at reset values, no result_done. start during busy -> ignored.

Source files
------------

// File: rtl/eeprom_pkg.sv
// ----------------------------------------------------------------------------
// eeprom_pkg
// Shared definitions for the EEPROM self-test sequencer:
//   - state_e      : sequencer state encoding
//   - MODE_*       : run mode codes (sampled at start)
//   - PAT_*        : data pattern codes (sampled at start)
//   - LFSR_SEED / LFSR_TAPS and lfsr_next() : 8-bit Galois LFSR,
//     polynomial x^8 + x^6 + x^5 + x^4 + 1
// ----------------------------------------------------------------------------
package eeprom_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_WR_GAP,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_DONE
    } state_e;

    localparam logic [1:0] MODE_WR_VERIFY     = 2'd0;
    localparam logic [1:0] MODE_WR_ONLY       = 2'd1;
    localparam logic [1:0] MODE_VERIFY_ONLY   = 2'd2;
    localparam logic [1:0] MODE_WR_VERIFY_ALT = 2'd3;  // behaves as MODE_WR_VERIFY

    localparam logic [1:0] PAT_ADDR     = 2'd0;  // addr[7:0]
    localparam logic [1:0] PAT_INV_ADDR = 2'd1;  // ~addr[7:0]
    localparam logic [1:0] PAT_LFSR     = 2'd2;  // LFSR8 sequence
    localparam logic [1:0] PAT_CHECKER  = 2'd3;  // addr[0] ? AA : 55

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Right-shifting Galois form: feedback taps for x^8, x^6, x^5, x^4.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/eeprom_bist_if.sv
// ----------------------------------------------------------------------------
// eeprom_bist_if
// Byte-level IIC master handshake between the self-test sequencer and the
// IIC master.
//   iic_bit_ctrl : 1 = 16-bit word address, 0 = 8-bit
//   iic_exec     : one-cycle transaction request
//   iic_rh_wl    : 1 read, 0 write; stable from exec to done
//   iic_addr     : word address
//   iic_data_w   : write data
//   iic_done     : one-cycle pulse, transaction finished
//   iic_ack      : 1 = NACK / error in the finished transaction
//   iic_data_r   : read data, valid with iic_done
// Modports: master = sequencer side, slave = IIC master side.
// ----------------------------------------------------------------------------
interface eeprom_bist_if;

    logic        iic_bit_ctrl;
    logic        iic_exec;
    logic        iic_rh_wl;
    logic [15:0] iic_addr;
    logic [7:0]  iic_data_w;
    logic        iic_done;
    logic        iic_ack;
    logic [7:0]  iic_data_r;

    modport master (
        output iic_bit_ctrl, iic_exec, iic_rh_wl, iic_addr, iic_data_w,
        input  iic_done, iic_ack, iic_data_r
    );

    modport slave (
        input  iic_bit_ctrl, iic_exec, iic_rh_wl, iic_addr, iic_data_w,
        output iic_done, iic_ack, iic_data_r
    );

endinterface

// File: rtl/eeprom_pattern_gen.sv
// ----------------------------------------------------------------------------
// eeprom_pattern_gen
// Test data generator: selects the expected/written byte for the current
// address and owns the LFSR used by the pseudo-random pattern.
//   iic_4_clk, rstn : clock, async active-low reset
//   pat_sel_i       : pattern code (PAT_*)
//   addr_i          : low byte of the current bus address
//   seed_i          : reload LFSR with LFSR_SEED (wins over step_i)
//   step_i          : advance LFSR one step
//   data_o          : pattern byte for the current address
// ----------------------------------------------------------------------------
module eeprom_pattern_gen
    import eeprom_pkg::*;
(
    input  logic       iic_4_clk,
    input  logic       rstn,
    input  logic [1:0] pat_sel_i,
    input  logic [7:0] addr_i,
    input  logic       seed_i,
    input  logic       step_i,
    output logic [7:0] data_o
);

    logic [7:0] lfsr_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register in the design samples pre-edge values, whatever the block order.
    always_ff @(posedge iic_4_clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= LFSR_SEED;
        end else if (seed_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (step_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    // NOTE: a default assignment ahead of the case keeps this purely
    // combinational; a missed path would otherwise infer a latch.
    always_comb begin
        data_o = addr_i;
        unique case (pat_sel_i)
            PAT_ADDR:     data_o = addr_i;
            PAT_INV_ADDR: data_o = ~addr_i;
            PAT_LFSR:     data_o = lfsr_q;
            PAT_CHECKER:  data_o = addr_i[0] ? 8'hAA : 8'h55;
            default:      data_o = addr_i;
        endcase
    end

endmodule

// File: rtl/eeprom_bist.sv
// ----------------------------------------------------------------------------
// eeprom_bist
// Self-test sequencer for an I2C EEPROM. A run writes a pattern over the
// address window [START_ADDR, START_ADDR+LENGTH-1] (wrapping), then reads it
// back and compares. Write NACKs are retried up to MAX_RETRY times; every write
// attempt is followed by WR_WAIT idle cycles (EEPROM tWR).
//   iic_4_clk, rstn : clock, async active-low reset
//   start           : one-cycle run request, ignored while busy
//   mode, pattern   : run mode / data pattern, sampled at start
//   iic             : IIC master handshake (master modport)
//   busy            : run in progress
//   result_done     : one-cycle pulse at end of run
//   result_flag     : 1 = pass, held until next start
//   err_cnt         : read mismatches + read NACKs, saturating
//   fail_addr       : address of first failure, 16'hFFFF if none
// ----------------------------------------------------------------------------
module eeprom_bist
    import eeprom_pkg::*;
#(
    parameter int          ADDR16     = 1,
    parameter logic [15:0] START_ADDR = 16'h0000,
    parameter int          LENGTH     = 256,
    parameter int          WR_WAIT    = 5000,
    parameter int          MAX_RETRY  = 3
) (
    input  logic          iic_4_clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [1:0]    pattern,
    eeprom_bist_if.master iic,
    output logic          busy,
    output logic          result_done,
    output logic          result_flag,
    output logic [15:0]   err_cnt,
    output logic [15:0]   fail_addr
);

    if (LENGTH < 1 || LENGTH > 65536) begin : g_bad_length
        $error("eeprom_bist: LENGTH must be in 1..65536");
    end
    if (WR_WAIT < 1 || WR_WAIT > 65536) begin : g_bad_wr_wait
        $error("eeprom_bist: WR_WAIT must be in 1..65536");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 255) begin : g_bad_retry
        $error("eeprom_bist: MAX_RETRY must be in 0..255");
    end

    localparam logic [15:0] LAST_CNT  = 16'(LENGTH - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(WR_WAIT - 1);
    localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);

    state_e      state_q;
    logic [1:0]  mode_q;
    logic [1:0]  pat_q;
    logic [15:0] addr_cnt_q;
    logic [15:0] gap_q;
    logic [7:0]  retry_q;
    logic        redo_q;        // current gap ends in a retry of the same address
    logic        abort_q;       // write retries exhausted
    logic        fail_seen_q;   // fail_addr already captured this run
    logic        exec_q;
    logic        rh_wl_q;
    logic [15:0] addr_q;
    logic [7:0]  data_w_q;
    logic        busy_q;
    logic        result_done_q;
    logic        result_flag_q;
    logic [15:0] err_cnt_q;
    logic [15:0] fail_addr_q;

    logic [15:0] win_addr;
    logic [15:0] cur_addr;
    logic        last;
    logic [7:0]  pat_data;
    logic        lfsr_seed;
    logic        lfsr_step;
    logic        rd_err;

    // Window address wraps modulo 2^16; in 8-bit mode the upper byte is forced
    // to zero so the window wraps at FF instead.
    assign win_addr = START_ADDR + addr_cnt_q;
    assign cur_addr = (ADDR16 != 0) ? win_addr : {8'h00, win_addr[7:0]};
    assign last     = (addr_cnt_q == LAST_CNT);
    assign rd_err   = iic.iic_ack || (iic.iic_data_r != pat_data);

    eeprom_pattern_gen u_pattern_gen (
        .iic_4_clk (iic_4_clk),
        .rstn      (rstn),
        .pat_sel_i (pat_q),
        .addr_i    (cur_addr[7:0]),
        .seed_i    (lfsr_seed),
        .step_i    (lfsr_step),
        .data_o    (pat_data)
    );

    // The LFSR moves once per accepted address so the verify pass regenerates
    // exactly the sequence the write pass produced; it is reseeded at start and
    // again between the write and verify passes.
    always_comb begin
        lfsr_seed = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_q)
            ST_IDLE: lfsr_seed = start;
            ST_WR_GAP: begin
                if (gap_q == 16'd0 && !redo_q) begin
                    if (!last) begin
                        lfsr_step = 1'b1;
                    end else if (mode_q != MODE_WR_ONLY) begin
                        lfsr_seed = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: lfsr_step = iic.iic_done && !last;
            default: ;
        endcase
    end

    // NOTE: only control/status registers take the async reset; there is no
    // memory here, and every datapath register is reloaded before it is used.
    always_ff @(posedge iic_4_clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_WR_VERIFY;
            pat_q         <= PAT_ADDR;
            addr_cnt_q    <= '0;
            gap_q         <= '0;
            retry_q       <= '0;
            redo_q        <= 1'b0;
            abort_q       <= 1'b0;
            fail_seen_q   <= 1'b0;
            exec_q        <= 1'b0;
            rh_wl_q       <= 1'b0;
            addr_q        <= '0;
            data_w_q      <= '0;
            busy_q        <= 1'b0;
            result_done_q <= 1'b0;
            result_flag_q <= 1'b0;
            err_cnt_q     <= '0;
            fail_addr_q   <= 16'hFFFF;
        end else begin
            exec_q        <= 1'b0;
            result_done_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q        <= (mode == MODE_WR_VERIFY_ALT) ? MODE_WR_VERIFY : mode;
                        pat_q         <= pattern;
                        addr_cnt_q    <= '0;
                        retry_q       <= '0;
                        redo_q        <= 1'b0;
                        abort_q       <= 1'b0;
                        fail_seen_q   <= 1'b0;
                        err_cnt_q     <= '0;
                        result_flag_q <= 1'b0;
                        fail_addr_q   <= 16'hFFFF;
                        busy_q        <= 1'b1;
                        state_q       <= (mode == MODE_VERIFY_ONLY) ? ST_RD_REQ : ST_WR_REQ;
                    end
                end

                ST_WR_REQ: begin
                    exec_q   <= 1'b1;
                    rh_wl_q  <= 1'b0;
                    addr_q   <= cur_addr;
                    data_w_q <= pat_data;
                    state_q  <= ST_WR_WAIT;
                end

                ST_WR_WAIT: begin
                    if (iic.iic_done) begin
                        if (!iic.iic_ack) begin
                            gap_q   <= GAP_LOAD;
                            state_q <= ST_WR_GAP;
                        end else if (retry_q < RETRY_LIM) begin
                            retry_q <= retry_q + 8'd1;
                            redo_q  <= 1'b1;
                            gap_q   <= GAP_LOAD;
                            state_q <= ST_WR_GAP;
                        end else begin
                            if (!fail_seen_q) begin
                                fail_addr_q <= addr_q;
                                fail_seen_q <= 1'b1;
                            end
                            abort_q <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_WR_GAP: begin
                    if (gap_q != 16'd0) begin
                        gap_q <= gap_q - 16'd1;
                    end else if (redo_q) begin
                        redo_q  <= 1'b0;
                        state_q <= ST_WR_REQ;
                    end else begin
                        retry_q <= '0;
                        if (!last) begin
                            addr_cnt_q <= addr_cnt_q + 16'd1;
                            state_q    <= ST_WR_REQ;
                        end else if (mode_q == MODE_WR_ONLY) begin
                            state_q <= ST_DONE;
                        end else begin
                            addr_cnt_q <= '0;
                            state_q    <= ST_RD_REQ;
                        end
                    end
                end

                ST_RD_REQ: begin
                    exec_q  <= 1'b1;
                    rh_wl_q <= 1'b1;
                    addr_q  <= cur_addr;
                    state_q <= ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    if (iic.iic_done) begin
                        if (rd_err) begin
                            if (err_cnt_q != 16'hFFFF) begin
                                err_cnt_q <= err_cnt_q + 16'd1;
                            end
                            if (!fail_seen_q) begin
                                fail_addr_q <= addr_q;
                                fail_seen_q <= 1'b1;
                            end
                        end
                        if (last) begin
                            state_q <= ST_DONE;
                        end else begin
                            addr_cnt_q <= addr_cnt_q + 16'd1;
                            state_q    <= ST_RD_REQ;
                        end
                    end
                end

                ST_DONE: begin
                    result_done_q <= 1'b1;
                    result_flag_q <= !abort_q && (err_cnt_q == 16'd0);
                    busy_q        <= 1'b0;
                    state_q       <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign iic.iic_bit_ctrl = (ADDR16 != 0);
    assign iic.iic_exec     = exec_q;
    assign iic.iic_rh_wl    = rh_wl_q;
    assign iic.iic_addr     = addr_q;
    assign iic.iic_data_w   = data_w_q;

    assign busy        = busy_q;
    assign result_done = result_done_q;
    assign result_flag = result_flag_q;
    assign err_cnt     = err_cnt_q;
    assign fail_addr   = fail_addr_q;

endmodule

// File: tb/tb_eeprom_bist.sv
// ----------------------------------------------------------------------------
// tb_eeprom_bist
// Two sequencers share a clock: dut_a (16-bit addressing, window 0000..0003)
// and dut_b (8-bit addressing, window FE..01, wrapping). Each sits on a
// behavioural IIC master + EEPROM model that answers exec with a done pulse
// two cycles later. Model A can NACK writes to one address and corrupt reads
// of one address; it also records the idle cycles after each write.
// ----------------------------------------------------------------------------
module tb_eeprom_bist;
    import eeprom_pkg::*;

    localparam int W = 8;  // WR_WAIT used by both instances

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr;
    logic        start_a, start_b;
    logic [1:0]  mode_a, pattern_a, mode_b, pattern_b;
    logic        busy_a, done_a, flag_a, busy_b, done_b, flag_b;
    logic [15:0] err_a, fail_a, err_b, fail_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit done_seen, busy_seen, seen;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eeprom_bist_if bus_a ();
    eeprom_bist_if bus_b ();

    eeprom_bist #(
        .ADDR16(1), .START_ADDR(16'h0000), .LENGTH(4), .WR_WAIT(W), .MAX_RETRY(3)
    ) dut_a (
        .iic_4_clk(clk), .rstn(rstn), .start(start_a), .mode(mode_a), .pattern(pattern_a),
        .iic(bus_a), .busy(busy_a), .result_done(done_a), .result_flag(flag_a),
        .err_cnt(err_a), .fail_addr(fail_a)
    );

    eeprom_bist #(
        .ADDR16(0), .START_ADDR(16'h00FE), .LENGTH(4), .WR_WAIT(W), .MAX_RETRY(3)
    ) dut_b (
        .iic_4_clk(clk), .rstn(rstn), .start(start_b), .mode(mode_b), .pattern(pattern_b),
        .iic(bus_b), .busy(busy_b), .result_done(done_b), .result_flag(flag_b),
        .err_cnt(err_b), .fail_addr(fail_b)
    );

    // ---------------- model A ----------------
    logic [7:0]  mem_a [256];
    int          a_wr_cnt [256];
    int          a_rd_cnt [256];
    int          a_wr_total, a_rd_total, a_nack_given, a_min_gap, a_overlap;
    int          a_nack_limit;
    logic [15:0] a_nack_addr, a_corrupt_addr;
    logic        a_corrupt_en;
    int          a_lat, a_last_wr;
    logic        a_pend, a_rh, a_wr_valid;
    logic [15:0] a_adr;
    logic [7:0]  a_wd;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_a.iic_done   <= 1'b0;
            bus_a.iic_ack    <= 1'b0;
            bus_a.iic_data_r <= 8'h00;
            a_pend     = 1'b0;
            a_lat      = 0;
            a_wr_valid = 1'b0;
        end else begin
            bus_a.iic_done <= 1'b0;
            if (clr) begin
                a_wr_total = 0; a_rd_total = 0; a_nack_given = 0;
                a_min_gap = 1000000; a_overlap = 0; a_wr_valid = 1'b0;
                for (int i = 0; i < 256; i++) begin a_wr_cnt[i] = 0; a_rd_cnt[i] = 0; end
            end
            if (a_pend) begin
                if (bus_a.iic_exec) a_overlap++;
                a_lat--;
                if (a_lat == 0) begin
                    a_pend = 1'b0;
                    bus_a.iic_done <= 1'b1;
                    if (a_rh) begin
                        a_rd_total++;
                        a_rd_cnt[a_adr[7:0]]++;
                        bus_a.iic_ack    <= 1'b0;
                        bus_a.iic_data_r <= mem_a[a_adr[7:0]] ^
                            ((a_corrupt_en && a_adr == a_corrupt_addr) ? 8'hFF : 8'h00);
                    end else begin
                        a_wr_total++;
                        a_wr_cnt[a_adr[7:0]]++;
                        if (a_adr == a_nack_addr && a_nack_given < a_nack_limit) begin
                            a_nack_given++;
                            bus_a.iic_ack <= 1'b1;
                        end else begin
                            mem_a[a_adr[7:0]] = a_wd;
                            bus_a.iic_ack <= 1'b0;
                        end
                        a_last_wr  = cyc;
                        a_wr_valid = 1'b1;
                    end
                end
            end else if (bus_a.iic_exec) begin
                a_pend = 1'b1;
                a_lat  = 2;
                a_rh   = bus_a.iic_rh_wl;
                a_adr  = bus_a.iic_addr;
                a_wd   = bus_a.iic_data_w;
                // done high during (p, p+1); exec seen at edge e was high during (e-1, e)
                if (a_wr_valid) begin
                    if (cyc - a_last_wr - 2 < a_min_gap) a_min_gap = cyc - a_last_wr - 2;
                    a_wr_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- model B ----------------
    logic [7:0]  mem_b [256];
    logic [15:0] b_log [8];
    int          b_log_n, b_wr_total, b_rd_total, b_lat;
    logic        b_pend, b_rh;
    logic [15:0] b_adr;
    logic [7:0]  b_wd;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_b.iic_done   <= 1'b0;
            bus_b.iic_ack    <= 1'b0;
            bus_b.iic_data_r <= 8'h00;
            b_pend = 1'b0;
            b_lat  = 0;
        end else begin
            bus_b.iic_done <= 1'b0;
            if (clr) begin b_log_n = 0; b_wr_total = 0; b_rd_total = 0; end
            if (b_pend) begin
                b_lat--;
                if (b_lat == 0) begin
                    b_pend = 1'b0;
                    bus_b.iic_done <= 1'b1;
                    bus_b.iic_ack  <= 1'b0;
                    if (b_rh) begin
                        b_rd_total++;
                        bus_b.iic_data_r <= mem_b[b_adr[7:0]];
                    end else begin
                        b_wr_total++;
                        mem_b[b_adr[7:0]] = b_wd;
                        if (b_log_n < 8) begin b_log[b_log_n] = b_adr; b_log_n++; end
                    end
                end
            end else if (bus_b.iic_exec) begin
                b_pend = 1'b1;
                b_lat  = 2;
                b_rh   = bus_b.iic_rh_wl;
                b_adr  = bus_b.iic_addr;
                b_wd   = bus_b.iic_data_w;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start (with a model counter clear) and waits, bounded, for result_done.
    task automatic run(input bit on_b, input logic [1:0] md, input logic [1:0] pt);
        done_seen = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        if (on_b) begin start_b = 1'b1; mode_b = md; pattern_b = pt; end
        else      begin start_a = 1'b1; mode_a = md; pattern_a = pt; end
        @(negedge clk);
        clr = 1'b0; start_a = 1'b0; start_b = 1'b0;
        busy_seen = on_b ? busy_b : busy_a;
        for (int i = 0; i < 3000 && !done_seen; i++) begin
            @(negedge clk);
            if (on_b ? done_b : done_a) done_seen = 1'b1;
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0]  exp_b_data [4];
    logic [15:0] exp_b_addr [4];

    initial begin
        exp_b_data[0] = 8'hA5; exp_b_data[1] = 8'hEA; exp_b_data[2] = 8'h75; exp_b_data[3] = 8'h82;
        exp_b_addr[0] = 16'h00FE; exp_b_addr[1] = 16'h00FF; exp_b_addr[2] = 16'h0000; exp_b_addr[3] = 16'h0001;
        rstn = 1'b0; clr = 1'b0;
        start_a = 1'b0; mode_a = 2'd0; pattern_a = 2'd0;
        start_b = 1'b0; mode_b = 2'd0; pattern_b = 2'd0;
        a_nack_limit = 0; a_nack_addr = 16'h0; a_corrupt_en = 1'b0; a_corrupt_addr = 16'h0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst busy", busy_a, 1'b0);
        check("rst result_done", done_a, 1'b0);
        check("rst flag", flag_a, 1'b0);
        check("rst err_cnt", err_a, 16'h0000);
        check("rst fail_addr", fail_a, 16'hFFFF);
        check("rst exec", bus_a.iic_exec, 1'b0);
        check("rst addr", bus_a.iic_addr, 16'h0000);
        check("bit_ctrl a", bus_a.iic_bit_ctrl, 1'b1);
        check("bit_ctrl b", bus_b.iic_bit_ctrl, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        // Write+verify, address pattern
        run(1'b0, MODE_WR_VERIFY, PAT_ADDR);
        check("t1 done", done_seen, 1'b1);
        check("t1 busy during run", busy_seen, 1'b1);
        check("t1 busy at done", busy_a, 1'b0);
        check("t1 flag", flag_a, 1'b1);
        check("t1 err_cnt", err_a, 16'h0000);
        check("t1 fail_addr", fail_a, 16'hFFFF);
        for (int i = 0; i < 4; i++) check($sformatf("t1 mem[%0d]", i), mem_a[i], 8'(i));
        check("t1 writes", a_wr_total, 4);
        check("t1 reads", a_rd_total, 4);
        check("t1 gap>=WR_WAIT", a_min_gap >= W, 1'b1);
        check("t1 single outstanding", a_overlap, 0);

        // Write-only, inverted address
        run(1'b0, MODE_WR_ONLY, PAT_INV_ADDR);
        check("t1b done", done_seen, 1'b1);
        check("t1b flag", flag_a, 1'b1);
        check("t1b reads", a_rd_total, 0);
        for (int i = 0; i < 4; i++) check($sformatf("t1b mem[%0d]", i), mem_a[i], 8'hFF - 8'(i));

        // Mode 3 behaves as write+verify, checkerboard
        run(1'b0, MODE_WR_VERIFY_ALT, PAT_CHECKER);
        check("t1c flag", flag_a, 1'b1);
        check("t1c reads", a_rd_total, 4);
        check("t1c mem[0]", mem_a[0], 8'h55);
        check("t1c mem[1]", mem_a[1], 8'hAA);
        check("t1c mem[3]", mem_a[3], 8'hAA);

        // Corrupted read at address 2; verify continues
        a_corrupt_en = 1'b1; a_corrupt_addr = 16'h0002;
        run(1'b0, MODE_WR_VERIFY, PAT_ADDR);
        a_corrupt_en = 1'b0;
        check("t2 done", done_seen, 1'b1);
        check("t2 flag", flag_a, 1'b0);
        check("t2 err_cnt", err_a, 16'h0001);
        check("t2 fail_addr", fail_a, 16'h0002);
        check("t2 read addr3 issued", a_rd_cnt[3], 1);

        // Two NACKs at address 1, recovered by retry
        a_nack_addr = 16'h0001; a_nack_limit = 2;
        run(1'b0, MODE_WR_VERIFY, PAT_ADDR);
        check("t3 done", done_seen, 1'b1);
        check("t3 writes addr1", a_wr_cnt[1], 3);
        check("t3 writes total", a_wr_total, 6);
        check("t3 gap>=WR_WAIT", a_min_gap >= W, 1'b1);
        check("t3 flag", flag_a, 1'b1);
        check("t3 fail_addr", fail_a, 16'hFFFF);

        // Persistent NACK at address 0: abort after 1+MAX_RETRY attempts
        a_nack_addr = 16'h0000; a_nack_limit = 1000;
        run(1'b0, MODE_WR_VERIFY, PAT_ADDR);
        a_nack_limit = 0;
        check("t4 done", done_seen, 1'b1);
        check("t4 attempts", a_wr_cnt[0], 4);
        check("t4 reads", a_rd_total, 0);
        check("t4 flag", flag_a, 1'b0);
        check("t4 fail_addr", fail_a, 16'h0000);
        check("t4 err_cnt", err_a, 16'h0000);

        // 8-bit addressing window FE..01 with LFSR data
        run(1'b1, MODE_WR_VERIFY, PAT_LFSR);
        check("t5 done", done_seen, 1'b1);
        check("t5 flag", flag_b, 1'b1);
        check("t5 writes", b_wr_total, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5 addr%0d", i), b_log[i], exp_b_addr[i]);
            check($sformatf("t5 data%0d", i), mem_b[exp_b_addr[i][7:0]], exp_b_data[i]);
        end
        run(1'b1, MODE_VERIFY_ONLY, PAT_LFSR);
        check("t5 verify flag", flag_b, 1'b1);
        check("t5 verify writes", b_wr_total, 0);
        check("t5 verify reads", b_rd_total, 4);
        run(1'b1, MODE_VERIFY_ONLY, PAT_ADDR);
        check("t5 wrong pat flag", flag_b, 1'b0);
        check("t5 wrong pat err_cnt", err_b, 16'h0004);
        check("t5 wrong pat fail_addr", fail_b, 16'h00FE);

        // start while busy is ignored
        @(negedge clk);
        clr = 1'b1; start_a = 1'b1; mode_a = MODE_WR_VERIFY; pattern_a = PAT_ADDR;
        @(negedge clk);
        clr = 1'b0; start_a = 1'b0;
        repeat (6) @(negedge clk);
        start_a = 1'b1; mode_a = MODE_WR_ONLY;
        @(negedge clk);
        start_a = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 3000 && !done_seen; i++) begin
            @(negedge clk);
            if (done_a) done_seen = 1'b1;
        end
        check("t6 done", done_seen, 1'b1);
        check("t6 writes", a_wr_total, 4);
        check("t6 reads", a_rd_total, 4);
        check("t6 flag", flag_a, 1'b1);

        // Reset in the middle of WR_GAP
        @(negedge clk);
        clr = 1'b1; start_a = 1'b1; mode_a = MODE_WR_VERIFY; pattern_a = PAT_ADDR;
        @(negedge clk);
        clr = 1'b0; start_a = 1'b0;
        for (int i = 0; i < 200 && a_wr_total == 0; i++) @(negedge clk);
        check("t7 first write done", a_wr_total, 1);
        repeat (3) @(negedge clk);
        check("t7 busy before reset", busy_a, 1'b1);
        rstn = 1'b0;
        #1;
        check("t7 exec", bus_a.iic_exec, 1'b0);
        check("t7 busy", busy_a, 1'b0);
        check("t7 result_done", done_a, 1'b0);
        check("t7 fail_addr", fail_a, 16'hFFFF);
        check("t7 err_cnt", err_a, 16'h0000);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_a || bus_a.iic_exec) seen = 1'b1;
        end
        check("t7 no activity after reset", seen, 1'b0);
        check("t7 idle busy", busy_a, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
